// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of one prng among NUM_REQ requesters.
// Latency: req seen in IDLE at cycle c -> rsp_valid at c+L+2 (L = ready delay after gen).
// Backpressure: one transaction outstanding; other requests wait at level until granted.
//
// Ports: clk/rst (async active-high); req/gnt per-requester request and
// one-hot grant; rsp_valid/rsp_id/rsp_data/rsp_err response pulse; busy
// (not IDLE); prng_gen/prng_ready/prng_number drive and sample the prng.
// Optional macro PRNG_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and
// answers with rsp_err=1, rsp_data=0 when the prng never becomes ready.
module prng_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 4,
  parameter int TIMEOUT  = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [NUM_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                prng_gen,
  input  logic                prng_ready,
  input  logic [NUM_BITS-1:0] prng_number
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_param_check
    $error("prng_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DELIVER
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick_id;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W:0]     idx;
  logic              found;

`ifdef PRNG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Search from rr_ptr upward with wrap-around; idx carries one extra bit
  // so ptr + offset never overflows before the wrap subtraction.
  always_comb begin
    pick_id = '0;
    pick_oh = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req[idx[ID_W-1:0]]) begin
        found   = 1'b1;
        pick_id = idx[ID_W-1:0];
      end
    end
    pick_oh[pick_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      prng_gen  <= 1'b0;
`ifdef PRNG_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      prng_gen  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt      <= pick_oh;
            rsp_id   <= pick_id;
            prng_gen <= 1'b1;   // high for exactly the ISSUE cycle
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_ARM;
        end
        S_ARM: begin
          // prng_ready here still reflects the previous number; skip it.
`ifdef PRNG_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (prng_ready) begin
            rsp_data  <= prng_number;
            rsp_valid <= 1'b1;
`ifdef PRNG_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_DELIVER;
          end
`ifdef PRNG_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_DELIVER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DELIVER: begin
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
`ifdef PRNG_ARB_TIMEOUT_EN
          rsp_err <= 1'b0;
`endif
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef PRNG_ARB_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
module tb_prng_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       prng_gen;
  logic       prng_ready  = 1'b1;
  logic [3:0] prng_number = 4'h0;

  prng_arbiter #(.NUM_REQ(4), .NUM_BITS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .prng_gen(prng_gen),
    .prng_ready(prng_ready), .prng_number(prng_number)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PRNG model: ready drops one cycle after the gen edge (so it is still
  // high during ARM), then rises lat cycles after the ISSUE cycle with the
  // next number from the table.
  logic [3:0] tbl [0:15];
  int         gen_idx = 0;
  int         lat     = 3;
  bit         hang    = 0;
  int         mcnt    = 0;
  bit         drop    = 0;
  logic [3:0] num_pending = 4'h0;

  initial begin
    tbl[0] = 4'hA; tbl[1] = 4'hF; tbl[2] = 4'h1; tbl[3] = 4'h2;
    tbl[4] = 4'h3; tbl[5] = 4'h4; tbl[6] = 4'h5; tbl[7] = 4'h6;
    tbl[8] = 4'h7; tbl[9] = 4'h8; tbl[10] = 4'h9; tbl[11] = 4'hE;
    tbl[12] = 4'hC; tbl[13] = 4'h0; tbl[14] = 4'h0; tbl[15] = 4'h0;
  end

  always @(posedge clk) begin
    if (prng_gen) begin
      mcnt        <= lat - 1;
      drop        <= 1'b1;
      num_pending <= tbl[gen_idx];
      gen_idx     <= gen_idx + 1;
    end else begin
      if (drop) begin
        prng_ready <= 1'b0;
        drop       <= 1'b0;
      end
      if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end else if (mcnt == 1) begin
        mcnt <= 0;
        if (!hang) begin
          prng_ready  <= 1'b1;
          prng_number <= num_pending;
        end
      end
    end
  end

  typedef struct {
    logic [1:0] id;
    logic [3:0] data;
    logic       err;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d data %0h at cycle %0d, expected none", rsp_id, rsp_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.at));
        chk("rsp_gnt", 32'(gnt), 32'(4'b0001 << mon_e.id));
      end
    end
  end

  int c0 = 0;

  task automatic drive(input logic [3:0] r);
    @(posedge clk);
    #1;
    req = r;
    c0  = cyc;
  endtask

  task automatic wait_rsp(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no rsp_valid within 200 cycles, expected a response", name);
    end
  endtask

  bit seen_busy;
  bit seen_gen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_prng_gen", 32'(prng_gen), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    rst = 1'b0;

    // Single request, ready 4 cycles after gen
    lat = 4;
    drive(4'b0010);
    sb.push_back('{2'd1, 4'hA, 1'b0, c0 + 6});
    @(posedge clk); #1;
    chk("single_gen_c1", 32'(prng_gen), 1);
    chk("single_gnt_c1", 32'(gnt), 32'(4'b0010));
    chk("single_busy_c1", 32'(busy), 1);
    @(posedge clk); #1;
    chk("single_gen_c2", 32'(prng_gen), 0);
    wait_rsp("single");
    req = 4'b0000;

    // Reset mid-WAIT: aborts with no response
    hang = 1;
    lat  = 3;
    drive(4'b0100);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_id", 32'(rsp_id), 0);
    chk("midrst_rsp_data", 32'(rsp_data), 0);
    chk("midrst_prng_gen", 32'(prng_gen), 0);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    hang = 0;
    seen_busy = 0;
    seen_gen  = 0;
    repeat (10) begin
      @(negedge clk);
      seen_busy = seen_busy | busy;
      seen_gen  = seen_gen | prng_gen;
    end
    chk("postrst_busy", 32'(seen_busy), 0);
    chk("postrst_gen", 32'(seen_gen), 0);

    // Round robin with all requests held: 0,1,2,3,0, one IDLE cycle apart
    lat = 3;
    drive(4'b1111);
    sb.push_back('{2'd0, 4'h1, 1'b0, c0 + 5});
    sb.push_back('{2'd1, 4'h2, 1'b0, c0 + 11});
    sb.push_back('{2'd2, 4'h3, 1'b0, c0 + 17});
    sb.push_back('{2'd3, 4'h4, 1'b0, c0 + 23});
    sb.push_back('{2'd0, 4'h5, 1'b0, c0 + 29});
    repeat (5) wait_rsp("round_robin");
    req = 4'b0000;

    // Withdraw during ARM while ready is still high from the prior number
    lat = 5;
    drive(4'b0100);
    sb.push_back('{2'd2, 4'h6, 1'b0, c0 + 7});
    repeat (2) @(posedge clk);
    #1;
    req = 4'b0000;
    wait_rsp("withdraw");

    // Pointer fairness: grant 3, then 1001 -> 0 then 3
    lat = 3;
    drive(4'b1000);
    sb.push_back('{2'd3, 4'h7, 1'b0, c0 + 5});
    wait_rsp("fair_pre");
    req = 4'b0000;
    drive(4'b1001);
    sb.push_back('{2'd0, 4'h8, 1'b0, c0 + 5});
    sb.push_back('{2'd3, 4'h9, 1'b0, c0 + 11});
    repeat (2) wait_rsp("fairness");
    req = 4'b0000;

`ifdef PRNG_ARB_TIMEOUT_EN
    // Never ready: error response 8 cycles after WAIT entry
    hang = 1;
    lat  = 3;
    drive(4'b0001);
    sb.push_back('{2'd0, 4'h0, 1'b1, c0 + 11});
    wait_rsp("timeout");
    req = 4'b0000;
    // Ready on the last allowed WAIT cycle wins over the timeout
    hang = 0;
    lat  = 9;
    drive(4'b0010);
    sb.push_back('{2'd1, 4'hC, 1'b0, c0 + 11});
    wait_rsp("timeout_edge");
    req = 4'b0000;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
